// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock, start/done handshake.
// Result register holds until the next accepted start.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       control,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic             carryOut,
    output logic             zero
);

    // state   | meaning
    // S_IDLE  | waiting for start, ready=1
    // S_SHIFT | applying one step per edge until count reaches 0
    // S_DONE  | result valid, one-cycle done pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] M_SLL = 3'b001;
    localparam logic [2:0] M_SRL = 3'b010;
    localparam logic [2:0] M_SRA = 3'b011;
    localparam logic [2:0] M_ROL = 3'b100;
    localparam logic [2:0] M_ROR = 3'b101;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               carry_q, carry_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH:0]     step_res;
    logic               is_pass;

    // Result is {carry, data}; unknown/pass modes leave data unchanged.
    function automatic logic [WIDTH:0] step(input logic [2:0] m, input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r;
        case (m)
            M_SLL:   r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            M_SRL:   r = {d[0], 1'b0, d[WIDTH-1:1]};
            M_SRA:   r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            M_ROL:   r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            M_ROR:   r = {d[0], d[0], d[WIDTH-1:1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    assign step_res = step(mode_q, data_q);
    assign is_pass  = (control == 3'b000) || (control[2:1] == 2'b11);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = data;
                    mode_d  = control;
                    count_d = amount;
                    carry_d = 1'b0;
                    state_d = (amount == '0 || is_pass) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                {carry_d, data_d} = step_res;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            mode_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign done     = (state_q == S_DONE);
    assign dataOut  = data_q;
    assign carryOut = carry_q;
    assign zero     = (data_q == '0);

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: directed ops push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_shifter;

    localparam int W = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    control = 3'b000;
    logic [AW-1:0] amount = '0;
    logic [W-1:0]  data = '0;
    logic          ready, busy, done, carryOut, zero;
    logic [W-1:0]  dataOut;

    seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .amount(amount), .data(data), .ready(ready), .busy(busy),
        .done(done), .dataOut(dataOut), .carryOut(carryOut), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] last_d;
    logic         last_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_data"}, dataOut, e.d);
                check({e.name, "_carry"}, {31'd0, carryOut}, {31'd0, e.c});
                check({e.name, "_zero"}, {31'd0, zero}, {31'd0, (e.d == '0)});
                check({e.name, "_latency"}, cyc, e.done_cyc);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Issue one op; k is the expected edge count from accept to done.
    task automatic issue(input string name, input logic [2:0] ctl, input logic [AW-1:0] amt,
                         input logic [W-1:0] d, input logic [W-1:0] exp_d, input logic exp_c,
                         input int k, input bit expect_result);
        exp_t e;
        wait_ready(name);
        @(negedge clk);
        control = ctl;
        amount  = amt;
        data    = d;
        start   = 1'b1;
        if (expect_result) begin
            e.d = exp_d; e.c = exp_c; e.done_cyc = cyc + 1 + k; e.name = name;
            exp_q.push_back(e);
            last_d = exp_d;
            last_c = exp_c;
        end
        @(negedge clk);
        start = 1'b0;
        check({name, "_ready_low"}, {31'd0, ready}, 32'd0);
    endtask

    task automatic finish_op(input string name);
        wait_ready(name);
        @(negedge clk);
        check({name, "_hold"}, dataOut, last_d);
    endtask

    initial begin
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", dataOut, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue("sll8", 3'b001, 5'd8, 32'h0000_00FF, 32'h0000_FF00, 1'b0, 8, 1);  finish_op("sll8");
        issue("sra1", 3'b011, 5'd1, 32'h8000_0000, 32'hC000_0000, 1'b0, 1, 1);  finish_op("sra1");
        issue("ror4", 3'b101, 5'd4, 32'h1234_5678, 32'h8123_4567, 1'b1, 4, 1);  finish_op("ror4");
        issue("srl31", 3'b010, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 31, 1); finish_op("srl31");
        issue("sll1z", 3'b001, 5'd1, 32'h8000_0000, 32'h0000_0000, 1'b1, 1, 1);  finish_op("sll1z");
        issue("pass", 3'b000, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 1);  finish_op("pass");
        issue("sll0", 3'b001, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 1);  finish_op("sll0");
        issue("rsv110", 3'b110, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 1); finish_op("rsv110");
        issue("rol4", 3'b100, 5'd4, 32'h1234_5678, 32'h2345_6781, 1'b1, 4, 1);  finish_op("rol4");
        issue("sra4", 3'b011, 5'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 4, 1);  finish_op("sra4");
        issue("srl1", 3'b010, 5'd1, 32'h0000_0001, 32'h0000_0000, 1'b1, 1, 1);  finish_op("srl1");
        check("carry_hold", {31'd0, carryOut}, {31'd0, last_c});

        // Second start while busy, with different inputs, must be ignored.
        issue("busy", 3'b001, 5'd20, 32'h0000_0001, 32'h0010_0000, 1'b0, 20, 1);
        repeat (3) @(negedge clk);
        control = 3'b010; amount = 5'd3; data = 32'hFFFF_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("busy");

        // Abort a 20-step shift mid-way with an async reset.
        issue("abort", 3'b001, 5'd20, 32'h0000_0003, 32'h0, 1'b0, 20, 0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_data", dataOut, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_zero", {31'd0, zero}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_done_data", dataOut, 32'd0);

        issue("post_rst", 3'b010, 5'd4, 32'h0000_00F0, 32'h0000_000F, 1'b0, 4, 1);
        finish_op("post_rst");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
